alu_result_stage: RTL and testbench
===================================

// Module: alu_result_stage
// PURPOSE
//   Execute->writeback stage that sits directly downstream of the ALU.
//   - Captures the ALU result, destination info and the new EFLAGS image into a small FIFO.
//   - Holds the architectural EFLAGS register and feeds it back to the ALU as eflags_as_src.
//   - Decouples ALU issue from writeback backpressure with a valid/ready handshake on both sides.
// PARAMETERS
//   DEPTH       2      FIFO entries; power of two, 2..8
//   REG_W       64     data and EFLAGS width (`REG_W)
//   DST_W       4      destination register index width
//   CNT_W       32     retire counter width
//   EFLAGS_RST  64'h2  EFLAGS reset image (bit1 reserved=1)
// PORTS
//   clk               in   1      clock, all state updates on rising edge
//   rstn              in   1      asynchronous active-low reset
//   flush             in   1      discard all buffered and incoming results
//   in_valid          in   1      ALU result valid
//   in_ready          out  1      stage can accept this cycle
//   in_d              in   REG_W  ALU result d
//   in_dst            in   DST_W  destination register index
//   in_wen            in   1      result is written to the register file
//   in_eflags         in   REG_W  ALU eflags output
//   in_eflags_update  in   1      ALU eflags_update
//   eflags_as_src     out  REG_W  architectural EFLAGS, returned to the ALU
//   out_valid         out  1      head entry valid toward writeback
//   out_ready         in   1      writeback accepts the head entry
//   out_d             out  REG_W  head result
//   out_dst           out  DST_W  head destination index
//   out_wen           out  1      head write enable
//   retire_cnt        out  CNT_W  count of completed output handshakes
// BEHAVIOUR
//   Reset (rstn=0, async):
//   - count=0, rd_ptr=wr_ptr=0, eflags_q=EFLAGS_RST, retire_cnt=0.
//   - Outputs: out_valid=0, in_ready=1, out_d/out_dst/out_wen=0.
//   - Reset asserted mid-transfer drops everything; no handshake completes in that cycle.
//   Handshakes:
//   - in_ready = (count != DEPTH) & ~flush. It is combinational from count and flush only, never from in_valid.
//   - push = in_valid & in_ready.
//   - pop  = out_valid & out_ready.
//   - out_valid = (count != 0). Head fields come from the mem[rd_ptr] registers: zero-latency show-ahead.
//   Latency:
//   - A pushed entry is visible at the output the cycle after the push. Minimum latency is 1 cycle.
//   - There is no bypass from input to output when the FIFO is empty.
//   FIFO:
//   - Push writes mem[wr_ptr]; wr_ptr increments mod DEPTH.
//   - Pop increments rd_ptr mod DEPTH.
//   - Push and pop in the same cycle leave count unchanged. This is legal at any count except full, where push is impossible.
//   - When full, in_ready=0 for that cycle even if pop=1. Reopening occurs the next cycle.
//   EFLAGS:
//   - eflags_q <= in_eflags on push & in_eflags_update.
//   - It updates at acceptance, not at retire, so back-to-back dependent ALU ops see the new flags one cycle later.
//   - No push, or in_eflags_update=0: eflags_q is held.
//   - eflags_as_src = eflags_q (registered, no combinational path from in_*).
//   Flush:
//   - flush=1: count, rd_ptr and wr_ptr are cleared next edge; out_valid=0 next cycle.
//   - in_ready=0 during flush, so an incoming op neither enters the FIFO nor updates EFLAGS.
//   - eflags_q keeps its value; the pipeline controller owns any flags recovery.
//   - A pop concurrent with flush still counts as retired (retire_cnt increments).
//   retire_cnt: increments by 1 on each pop and wraps 2^CNT_W-1 -> 0.
//   Invariants:
//   - out_* fields must stay stable while out_valid=1 & out_ready=0.
//   - count never exceeds DEPTH; pointer wrap never corrupts the order of entries.
// TESTING
//   1) Reset
//      - Stimulus: rstn low, then high.
//      - Required: eflags_as_src=64'h2, out_valid=0, in_ready=1, retire_cnt=0.
//   2) Single op
//      - Stimulus: push d=64'h5, dst=3, wen=1, eflags=64'h46, update=1; out_ready=1.
//      - Required: next cycle out_valid=1, out_d=5, out_dst=3; eflags_as_src=64'h46; retire_cnt=1 after that.
//   3) Backpressure with DEPTH=2
//      - Stimulus: out_ready=0; push A=1, B=2, then offer C=3.
//      - Required: in_ready=0 while C waits. After out_ready=1, order at the output is 1, 2, 3 with no loss or duplicate.
//   4) Flag gating
//      - Stimulus: push eflags=64'hFF with update=0.
//      - Required: eflags_as_src stays at its prior value 64'h46.
//   5) Flush
//      - Stimulus: 2 entries buffered; flush=1 together with in_valid=1, eflags=64'h1, update=1.
//      - Required: next cycle out_valid=0, count=0, eflags_as_src unchanged.
//   6) Wrap
//      - Stimulus: 1000 random push/pop cycles with out_ready randomized.
//      - Required: scoreboard order matches; retire_cnt equals the number of pops.
//      - Also: preload retire_cnt to all-ones, then one pop -> retire_cnt=0.

Source files
------------

// File: rtl/alu_result_stage.sv
// Execute->writeback buffer: queues ALU results in a show-ahead FIFO and owns the
// architectural EFLAGS register that is fed back to the ALU.
module alu_result_stage #(
  parameter int               DEPTH      = 2,
  parameter int               REG_W      = 64,
  parameter int               DST_W      = 4,
  parameter int               CNT_W      = 32,
  parameter logic [REG_W-1:0] EFLAGS_RST = REG_W'(2)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REG_W-1:0] in_d,
  input  logic [DST_W-1:0] in_dst,
  input  logic             in_wen,
  input  logic [REG_W-1:0] in_eflags,
  input  logic             in_eflags_update,
  output logic [REG_W-1:0] eflags_as_src,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REG_W-1:0] out_d,
  output logic [DST_W-1:0] out_dst,
  output logic             out_wen,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [REG_W-1:0] d;
    logic [DST_W-1:0] dst;
    logic             wen;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [REG_W-1:0] eflags_q, eflags_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             push, pop;

  // Ready depends only on occupancy and flush, so a full FIFO stays closed even
  // while the head is being popped; it reopens the following cycle.
  assign in_ready  = (count_q != CW'(DEPTH)) & ~flush;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    eflags_d = eflags_q;
    retire_d = retire_q;
    if (pop)  retire_d = retire_q + CNT_W'(1);
    // Flags commit at acceptance so a dependent op issued next cycle sees them.
    if (push && in_eflags_update) eflags_d = in_eflags;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      eflags_q <= EFLAGS_RST;
      retire_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      eflags_q <= eflags_d;
      retire_q <= retire_d;
      if (push) mem_q[wr_ptr_q] <= '{d: in_d, dst: in_dst, wen: in_wen};
    end
  end

  assign eflags_as_src = eflags_q;
  assign out_d         = mem_q[rd_ptr_q].d;
  assign out_dst       = mem_q[rd_ptr_q].dst;
  assign out_wen       = mem_q[rd_ptr_q].wen;
  assign retire_cnt    = retire_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench: driver records accepted ops in a queue model, a negedge monitor
// checks occupancy, head fields, flags and retire counts against it.
module tb_alu_result_stage;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_wen, in_eflags_update, out_ready;
  logic [63:0] in_d, in_eflags;
  logic [3:0]  in_dst;
  logic        in_ready, out_valid, out_wen;
  logic [63:0] eflags_as_src, out_d;
  logic [3:0]  out_dst;
  logic [31:0] retire_cnt;
  // narrow-counter copy, used to exercise retire counter wrap quickly
  logic        s_in_ready, s_out_valid, s_out_wen;
  logic [63:0] s_eflags, s_out_d;
  logic [3:0]  s_out_dst;
  logic [2:0]  s_retire;

  always #5 clk = ~clk;

  alu_result_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_d(in_d), .in_dst(in_dst), .in_wen(in_wen), .in_eflags(in_eflags),
    .in_eflags_update(in_eflags_update), .eflags_as_src(eflags_as_src),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_dst(out_dst),
    .out_wen(out_wen), .retire_cnt(retire_cnt));

  alu_result_stage #(.DEPTH(DEPTH), .CNT_W(3)) dut_s (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_d(in_d), .in_dst(in_dst), .in_wen(in_wen), .in_eflags(in_eflags),
    .in_eflags_update(in_eflags_update), .eflags_as_src(s_eflags),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_d(s_out_d), .out_dst(s_out_dst),
    .out_wen(s_out_wen), .retire_cnt(s_retire));

  typedef struct { logic [63:0] d; logic [3:0] dst; logic wen; } ent_t;
  ent_t        mq[$];
  logic [63:0] m_ef;
  int unsigned pops;
  int          n_cmp, n_bad;
  bit          started;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // One cycle of stimulus; the model commits at the clock edge that accepts it.
  task automatic drive(input bit v, input logic [63:0] d, input logic [3:0] dst, input bit wen,
                       input logic [63:0] ef, input bit upd, input bit ordy, input bit fl);
    bit acc;
    in_valid = v; in_d = d; in_dst = dst; in_wen = wen;
    in_eflags = ef; in_eflags_update = upd; out_ready = ordy; flush = fl;
    acc = v && !fl && (mq.size() != DEPTH);
    @(posedge clk);
    if (fl) mq.delete();
    if (acc) begin
      mq.push_back('{d: d, dst: dst, wen: wen});
      if (upd) m_ef = ef;
    end
    #1;
  endtask

  task automatic idle(input bit ordy, input int n);
    for (int i = 0; i < n; i++) drive(0, 64'h0, 4'h0, 0, 64'h0, 0, ordy, 0);
  endtask

  always @(negedge clk) begin
    if (rstn && started) begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (mq.size() != DEPTH) && !flush});
      chk("out_valid", {63'b0, out_valid}, {63'b0, mq.size() != 0});
      chk("eflags_as_src", eflags_as_src, m_ef);
      chk("retire_cnt", {32'b0, retire_cnt}, {32'b0, pops});
      chk("retire_cnt_wrap", {61'b0, s_retire}, {61'b0, pops[2:0]});
      if (mq.size() != 0) begin
        chk("out_d", out_d, mq[0].d);
        chk("out_dst", {60'b0, out_dst}, {60'b0, mq[0].dst});
        chk("out_wen", {63'b0, out_wen}, {63'b0, mq[0].wen});
        if (out_ready) begin
          void'(mq.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    rstn = 1'b0; flush = 0; in_valid = 0; in_d = '0; in_dst = '0; in_wen = 0;
    in_eflags = '0; in_eflags_update = 0; out_ready = 0;
    m_ef = 64'h2; pops = 0; n_cmp = 0; n_bad = 0; started = 0;
    #12;
    chk("rst_out_valid", {63'b0, out_valid}, 64'h0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'h1);
    chk("rst_eflags", eflags_as_src, 64'h2);
    chk("rst_retire", {32'b0, retire_cnt}, 64'h0);
    chk("rst_out_d", out_d, 64'h0);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    started = 1;

    // single op with flag update
    drive(1, 64'h5, 4'd3, 1, 64'h46, 1, 1, 0);
    idle(1, 3);
    // backpressure: A, B fill the FIFO, C waits
    drive(1, 64'h1, 4'd1, 1, 64'h0, 0, 0, 0);
    drive(1, 64'h2, 4'd2, 0, 64'h0, 0, 0, 0);
    drive(1, 64'h3, 4'd3, 1, 64'h0, 0, 0, 0);
    drive(1, 64'h3, 4'd3, 1, 64'h0, 0, 0, 0);
    drive(1, 64'h3, 4'd3, 1, 64'h0, 0, 1, 0);
    drive(1, 64'h3, 4'd3, 1, 64'h0, 0, 1, 0);
    idle(1, 4);
    // flag gating
    drive(1, 64'h7, 4'd7, 1, 64'hFF, 0, 1, 0);
    idle(1, 2);
    // flush with a concurrent op that must not enter or touch flags
    drive(1, 64'hA, 4'd10, 1, 64'h0, 0, 0, 0);
    drive(1, 64'hB, 4'd11, 1, 64'h0, 0, 0, 0);
    drive(1, 64'hC, 4'd12, 1, 64'h1, 1, 0, 1);
    idle(0, 2);
    idle(1, 1);
    // random traffic
    for (int i = 0; i < 1000; i++)
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, 4'($urandom), 1'($urandom),
            {$urandom, $urandom}, 1'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 2);
    idle(1, 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
